// File: rtl/rib_timer_pkg.sv
// Shared definitions for the multi-channel RIB timer: register map, CTRL bit
// positions, channel stride and the byte-lane write merge helper.
package rib_timer_pkg;

  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_PRESC  = 5'h04;
  localparam logic [4:0] OFF_CNT_LO = 5'h08;
  localparam logic [4:0] OFF_CNT_HI = 5'h0C;
  localparam logic [4:0] OFF_CMP_LO = 5'h10;
  localparam logic [4:0] OFF_CMP_HI = 5'h14;
  localparam logic [4:0] OFF_STAT   = 5'h18;

  localparam logic [11:0] ADDR_IRQ_VEC = 12'h400;

  localparam int CH_STRIDE = 32'h20;
  localparam int CH_SHIFT  = $clog2(CH_STRIDE);

  localparam int CTRL_EN  = 0;
  localparam int CTRL_ARL = 1;
  localparam int CTRL_OS  = 2;
  localparam int CTRL_IE  = 3;

  typedef enum logic [2:0] {
    REG_CTRL,
    REG_PRESC,
    REG_CNT_LO,
    REG_CNT_HI,
    REG_CMP_LO,
    REG_CMP_HI,
    REG_STAT,
    REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_off(input logic [4:0] off);
    case (off)
      OFF_CTRL:   return REG_CTRL;
      OFF_PRESC:  return REG_PRESC;
      OFF_CNT_LO: return REG_CNT_LO;
      OFF_CNT_HI: return REG_CNT_HI;
      OFF_CMP_LO: return REG_CMP_LO;
      OFF_CMP_HI: return REG_CMP_HI;
      OFF_STAT:   return REG_STAT;
      default:    return REG_NONE;
    endcase
  endfunction

  // Replace only the byte lanes whose mask bit is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  mask);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/rib_timer_chan.sv
// One timer channel: prescaler, counter with compare/auto-reload/one-shot,
// W1C pending flag and the CNT high-word shadow for coherent 64-bit reads.
module rib_timer_chan
  import rib_timer_pkg::*;
#(
  parameter int CNT_W = 64,
  parameter int PRE_W = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_ctrl_i,
  input  logic        wr_presc_i,
  input  logic        wr_cnt_lo_i,
  input  logic        wr_cnt_hi_i,
  input  logic        wr_cmp_lo_i,
  input  logic        wr_cmp_hi_i,
  input  logic        wr_stat_i,
  input  logic        rd_cnt_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  mask_i,
  output logic [3:0]  ctrl_o,
  output logic [31:0] presc_o,
  output logic [31:0] cnt_lo_o,
  output logic [31:0] shadow_o,
  output logic [31:0] cmp_lo_o,
  output logic [31:0] cmp_hi_o,
  output logic        pend_o
);

  logic [3:0]       ctrl_q,   ctrl_d;
  logic [PRE_W-1:0] presc_q,  presc_d;
  logic [PRE_W-1:0] pcnt_q,   pcnt_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] cmp_q,    cmp_d;
  logic             pend_q,   pend_d;
  logic [31:0]      shadow_q, shadow_d;

  // Registers widened to full bus width so lane merges are width-agnostic.
  logic [63:0] cnt_ext, cmp_ext, cnt_wr, cmp_wr;
  logic [31:0] presc_ext, presc_wr, ctrl_wr;
  logic        tick, match, cnt_write;

  always_comb begin
    cnt_ext   = '0;
    cmp_ext   = '0;
    presc_ext = '0;
    cnt_ext[CNT_W-1:0]   = cnt_q;
    cmp_ext[CNT_W-1:0]   = cmp_q;
    presc_ext[PRE_W-1:0] = presc_q;
  end

  assign tick      = ctrl_q[CTRL_EN] && (pcnt_q == presc_q);
  assign match     = tick && (cnt_q == cmp_q);
  assign cnt_write = wr_cnt_lo_i || (wr_cnt_hi_i && (CNT_W > 32));

  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    pcnt_d = '0;
    if (ctrl_q[CTRL_EN]) pcnt_d = tick ? '0 : pcnt_q + PRE_W'(1);

    cnt_wr = cnt_ext;
    if (wr_cnt_lo_i) cnt_wr[31:0]  = merge_bytes(cnt_ext[31:0],  wdata_i, mask_i);
    if (wr_cnt_hi_i) cnt_wr[63:32] = merge_bytes(cnt_ext[63:32], wdata_i, mask_i);

    // A bus write to the counter suppresses that cycle's increment.
    cnt_d = cnt_q;
    if (cnt_write)                      cnt_d = cnt_wr[CNT_W-1:0];
    else if (match && ctrl_q[CTRL_ARL]) cnt_d = '0;
    else if (tick)                      cnt_d = cnt_q + CNT_W'(1);

    cmp_wr = cmp_ext;
    if (wr_cmp_lo_i) cmp_wr[31:0]  = merge_bytes(cmp_ext[31:0],  wdata_i, mask_i);
    if (wr_cmp_hi_i) cmp_wr[63:32] = merge_bytes(cmp_ext[63:32], wdata_i, mask_i);
    cmp_d = cmp_wr[CNT_W-1:0];

    presc_wr = merge_bytes(presc_ext, wdata_i, mask_i);
    presc_d  = wr_presc_i ? presc_wr[PRE_W-1:0] : presc_q;

    ctrl_wr = merge_bytes({28'b0, ctrl_q}, wdata_i, mask_i);
    ctrl_d  = ctrl_q;
    if (match && ctrl_q[CTRL_OS]) ctrl_d[CTRL_EN] = 1'b0;
    if (wr_ctrl_i)                ctrl_d = ctrl_wr[3:0];

    pend_d = pend_q;
    if (wr_stat_i && mask_i[0] && wdata_i[0]) pend_d = 1'b0;
    if (match)                                pend_d = 1'b1;

    shadow_d = rd_cnt_lo_i ? cnt_ext[63:32] : shadow_q;
  end

  // NOTE: state registers use non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q   <= '0;
      presc_q  <= '0;
      pcnt_q   <= '0;
      cnt_q    <= '0;
      cmp_q    <= '0;
      pend_q   <= 1'b0;
      shadow_q <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
      cnt_q    <= cnt_d;
      cmp_q    <= cmp_d;
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
    end
  end

  assign ctrl_o   = ctrl_q;
  assign presc_o  = presc_ext;
  assign cnt_lo_o = cnt_ext[31:0];
  assign shadow_o = shadow_q;
  assign cmp_lo_o = cmp_ext[31:0];
  assign cmp_hi_o = cmp_ext[63:32];
  assign pend_o   = pend_q;

  // Bits beyond the configured widths are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{ctrl_wr, presc_wr, cnt_wr, cmp_wr, wdata_i, mask_i};

endmodule

// File: rtl/rib_timer_mc.sv
// Multi-channel RIB-slave timer: address decode, read mux and the
// single-outstanding req/gnt/rsp handshake around N_CH timer channels.
module rib_timer_mc
  import rib_timer_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 64,
  parameter int PRE_W = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [31:0]     i_ribs_addr,
  input  logic            i_ribs_wrcs,
  input  logic [3:0]      i_ribs_mask,
  input  logic [31:0]     i_ribs_wdata,
  output logic [31:0]     o_ribs_rdata,
  input  logic            i_ribs_req,
  output logic            o_ribs_gnt,
  output logic            o_ribs_rsp,
  input  logic            i_ribs_rdy,
  output logic [N_CH-1:0] o_irq
);

  logic        rsp_q, rsp_d;
  logic [31:0] rdata_q, rdata_d;

  logic [11:0] addr;
  logic [4:0]  ch_idx;
  reg_sel_e    reg_sel;
  logic        ch_hit, irq_hit, accept, wr_acc, rd_acc;
  logic [31:0] rd_val;

  assign addr    = i_ribs_addr[11:0];
  assign ch_idx  = addr[CH_SHIFT+4:CH_SHIFT];
  assign reg_sel = decode_off(addr[4:0]);
  assign ch_hit  = !addr[10] && (int'(ch_idx) < N_CH);
  assign irq_hit = (addr == ADDR_IRQ_VEC);

  assign o_ribs_gnt = i_ribs_req & (~rsp_q | i_ribs_rdy);
  assign accept     = i_ribs_req & o_ribs_gnt;
  assign wr_acc     = accept &  i_ribs_wrcs;
  assign rd_acc     = accept & ~i_ribs_wrcs;

  logic [3:0]      ctrl_a   [N_CH];
  logic [31:0]     presc_a  [N_CH];
  logic [31:0]     cnt_lo_a [N_CH];
  logic [31:0]     shadow_a [N_CH];
  logic [31:0]     cmp_lo_a [N_CH];
  logic [31:0]     cmp_hi_a [N_CH];
  logic [N_CH-1:0] pend_a;
  logic [N_CH-1:0] irq_vec;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic sel;
    assign sel = ch_hit && (ch_idx == 5'(g));

    rib_timer_chan #(
      .CNT_W (CNT_W),
      .PRE_W (PRE_W)
    ) u_chan (
      .clk_i       (i_clk),
      .rst_i       (i_rst),
      .wr_ctrl_i   (wr_acc && sel && (reg_sel == REG_CTRL)),
      .wr_presc_i  (wr_acc && sel && (reg_sel == REG_PRESC)),
      .wr_cnt_lo_i (wr_acc && sel && (reg_sel == REG_CNT_LO)),
      .wr_cnt_hi_i (wr_acc && sel && (reg_sel == REG_CNT_HI)),
      .wr_cmp_lo_i (wr_acc && sel && (reg_sel == REG_CMP_LO)),
      .wr_cmp_hi_i (wr_acc && sel && (reg_sel == REG_CMP_HI)),
      .wr_stat_i   (wr_acc && sel && (reg_sel == REG_STAT)),
      .rd_cnt_lo_i (rd_acc && sel && (reg_sel == REG_CNT_LO)),
      .wdata_i     (i_ribs_wdata),
      .mask_i      (i_ribs_mask),
      .ctrl_o      (ctrl_a[g]),
      .presc_o     (presc_a[g]),
      .cnt_lo_o    (cnt_lo_a[g]),
      .shadow_o    (shadow_a[g]),
      .cmp_lo_o    (cmp_lo_a[g]),
      .cmp_hi_o    (cmp_hi_a[g]),
      .pend_o      (pend_a[g])
    );

    assign irq_vec[g] = pend_a[g] & ctrl_a[g][CTRL_IE];
  end

  assign o_irq = irq_vec;

  always_comb begin
    rd_val = '0;
    if (irq_hit) begin
      rd_val[N_CH-1:0] = irq_vec;
    end else if (ch_hit) begin
      for (int c = 0; c < N_CH; c++) begin
        if (ch_idx == 5'(c)) begin
          case (reg_sel)
            REG_CTRL:   rd_val = {28'b0, ctrl_a[c]};
            REG_PRESC:  rd_val = presc_a[c];
            REG_CNT_LO: rd_val = cnt_lo_a[c];
            REG_CNT_HI: rd_val = shadow_a[c];
            REG_CMP_LO: rd_val = cmp_lo_a[c];
            REG_CMP_HI: rd_val = cmp_hi_a[c];
            REG_STAT:   rd_val = {31'b0, pend_a[c]};
            default:    rd_val = '0;
          endcase
        end
      end
    end
  end

  // A new accept in the rdy cycle keeps rsp high and loads fresh data.
  always_comb begin
    rsp_d   = rsp_q;
    rdata_d = rdata_q;
    if (accept) begin
      rsp_d   = 1'b1;
      rdata_d = i_ribs_wrcs ? 32'h0 : rd_val;
    end else if (i_ribs_rdy) begin
      rsp_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rsp_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      rsp_q   <= rsp_d;
      rdata_q <= rdata_d;
    end
  end

  assign o_ribs_rsp   = rsp_q;
  assign o_ribs_rdata = rdata_q;

  logic unused_addr;
  assign unused_addr = ^i_ribs_addr[31:12];

endmodule

// File: tb/tb_rib_timer_mc.sv
// Scoreboard bench for rib_timer_mc: reads push expected data, a monitor
// compares each accepted response; a few handshake/irq checks are direct.
module tb_rib_timer_mc;

  localparam int N_CH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     addr;
  logic            wrcs;
  logic [3:0]      mask;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic            req;
  logic            gnt;
  logic            rsp;
  logic            rdy;
  logic [N_CH-1:0] irq;

  always #5 clk = ~clk;

  rib_timer_mc #(.N_CH(N_CH), .CNT_W(64), .PRE_W(16)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_ribs_addr  (addr),
    .i_ribs_wrcs  (wrcs),
    .i_ribs_mask  (mask),
    .i_ribs_wdata (wdata),
    .o_ribs_rdata (rdata),
    .i_ribs_req   (req),
    .o_ribs_gnt   (gnt),
    .o_ribs_rsp   (rsp),
    .i_ribs_rdy   (rdy),
    .o_irq        (irq)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q [$];
  bit          chk_q [$];
  string       name_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a response is consumed on any edge where rsp and rdy are both high.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && rsp && rdy) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rdata 0x%08h, expected no response", rdata);
        end else begin
          logic [31:0] e;
          bit          c;
          string       n;
          e = exp_q.pop_front();
          c = chk_q.pop_front();
          n = name_q.pop_front();
          if (c) check(n, rdata, e);
        end
      end
    end
  end

  task automatic bus(input bit w, input logic [31:0] a, input logic [3:0] m,
                     input logic [31:0] d, input logic [31:0] e, input string name);
    bit g;
    int n;
    req   = 1'b1;
    wrcs  = w;
    addr  = a;
    mask  = m;
    wdata = d;
    exp_q.push_back(e);
    chk_q.push_back(!w);
    name_q.push_back(name);
    n = 0;
    g = 1'b0;
    do begin
      @(negedge clk);
      g = gnt;
      @(posedge clk);
      #1;
      n++;
    end while (!g && n < 20);
    if (!g) begin
      n_checks++;
      n_fail++;
      $display("FAIL gnt_timeout %s: got no grant, expected grant within 20 cycles", name);
    end
    req = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    bus(1'b1, a, m, d, 32'h0, "write");
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string name);
    bus(1'b0, a, 4'h0, 32'h0, e, name);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b1; req = 1'b0; wrcs = 1'b0; addr = '0; mask = '0; wdata = '0; rdy = 1'b1;
    idle(3);
    check("rst_rsp", 32'(rsp), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    rst = 1'b0;

    // Reset values through the bus
    rd(32'h000, 32'h0, "ch0_ctrl_rst");
    rd(32'h008, 32'h0, "ch0_cnt_lo_rst");
    rd(32'h400, 32'h0, "irq_vec_rst");

    // ch0 free-running at PRESC=0: counts once per cycle from the enable edge
    wr(32'h000, 4'hF, 32'h1);
    idle(9);
    rd(32'h008, 32'd9,  "ch0_cnt_a");
    rd(32'h008, 32'd10, "ch0_cnt_b");

    // ch1: PRESC=3 CMP=5 EN|ARL|IE -> match 24 cycles after enable
    wr(32'h024, 4'hF, 32'd3);
    wr(32'h030, 4'hF, 32'd5);
    wr(32'h020, 4'hF, 32'hB);
    idle(23);
    rd(32'h038, 32'h0, "ch1_stat_before_match");
    rd(32'h038, 32'h1, "ch1_stat_match");
    rd(32'h028, 32'h0, "ch1_cnt_reloaded");
    check("ch1_irq_set", 32'(irq), 32'h2);
    wr(32'h038, 4'hF, 32'h1);
    check("ch1_irq_w1c", 32'(irq), 32'h0);
    idle(20);
    check("ch1_irq_not_yet", 32'(irq), 32'h0);
    idle(1);
    check("ch1_irq_refire", 32'(irq), 32'h2);
    rd(32'h400, 32'h2, "irq_vec_ch1");
    wr(32'h020, 4'hF, 32'h0);
    wr(32'h038, 4'hF, 32'h1);
    wr(32'h024, 4'hF, 32'hFFFF_FFFF);
    rd(32'h024, 32'h0000_FFFF, "ch1_presc_width");

    // ch2 one-shot: CMP=2 EN|OS -> one match, EN cleared, counter frozen at 3
    wr(32'h050, 4'hF, 32'd2);
    wr(32'h040, 4'hF, 32'h5);
    idle(5);
    rd(32'h040, 32'h4, "ch2_ctrl_os_cleared");
    rd(32'h048, 32'd3, "ch2_cnt_frozen");
    rd(32'h058, 32'h1, "ch2_pend");
    wr(32'h058, 4'hF, 32'h1);
    idle(10);
    rd(32'h058, 32'h0, "ch2_pend_no_refire");

    // ch3 coherent read across the 32-bit carry
    wr(32'h06C, 4'hF, 32'h0);
    wr(32'h068, 4'hF, 32'hFFFF_FFFE);
    wr(32'h060, 4'hF, 32'h1);
    rd(32'h068, 32'hFFFF_FFFE, "ch3_lo_before_wrap");
    idle(3);
    rd(32'h06C, 32'h0, "ch3_hi_shadow_old");
    rd(32'h068, 32'd3, "ch3_lo_after_wrap");
    rd(32'h06C, 32'h1, "ch3_hi_shadow_new");

    // Response stall: rdy low holds rsp/rdata and blocks the next grant
    idle(2);
    rdy = 1'b0;
    rd(32'h040, 32'h4, "stall_first");
    req = 1'b1; wrcs = 1'b0; addr = 32'h048; mask = 4'h0;
    exp_q.push_back(32'd3);
    chk_q.push_back(1'b1);
    name_q.push_back("stall_second");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_gnt",   32'(gnt), 32'h0);
      check("stall_rsp",   32'(rsp), 32'h1);
      check("stall_rdata", rdata,    32'h4);
      @(posedge clk);
      #1;
    end
    rdy = 1'b1;
    @(negedge clk);
    check("stall_release_gnt", 32'(gnt), 32'h1);
    @(posedge clk);
    #1;
    req = 1'b0;

    // Mask 0 write, out-of-range channel, unmapped offset
    wr(32'h040, 4'h0, 32'hF);
    rd(32'h040, 32'h4, "ch2_ctrl_mask0");
    wr(32'h0A0, 4'hF, 32'h1);
    rd(32'h0A0, 32'h0, "ch5_ctrl");
    rd(32'h0A8, 32'h0, "ch5_cnt_lo");
    rd(32'h01C, 32'h0, "ch0_unmapped");

    // Counter writes on tick cycles (ch0 ticks every cycle)
    wr(32'h008, 4'hF, 32'h1234_5600);
    rd(32'h008, 32'h1234_5600, "ch0_cnt_write_tick");
    wr(32'h008, 4'h1, 32'hFFFF_FFAA);
    rd(32'h008, 32'h1234_56AA, "ch0_cnt_lane_write");
    rd(32'h00C, 32'h0, "ch0_cnt_hi");

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_drain: got %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rib_timer_mc.md
Name: rib_timer_mc

Overview:
- Multi-channel, parametrised RIB-slave timer; successor to the single 64-bit free-running timer peripheral.
- Adds per-channel prescaler, compare match, auto-reload and one-shot modes, W1C interrupt pending, byte-mask writes and coherent 64-bit reads.
- Sits on the peripheral RIB bus and drives per-channel interrupt lines to the interrupt controller.

Parameters:
- N_CH, 4, number of channels (1..32)
- CNT_W, 64, counter/compare width (32..64)
- PRE_W, 16, prescaler width (1..32)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; one clock, synchronous, active-high
- i_ribs_addr  in  32  byte address; decode uses [11:0]
- i_ribs_wrcs  in  1  1 = write, 0 = read
- i_ribs_mask  in  4  byte-lane write enables
- i_ribs_wdata  in  32  write data
- o_ribs_rdata  out  32  read data, valid while o_ribs_rsp = 1
- i_ribs_req  in  1  request
- o_ribs_gnt  out  1  grant
- o_ribs_rsp  out  1  response valid
- i_ribs_rdy  in  1  master accepts response
- o_irq  out  N_CH  per-channel interrupt, = pending & IE

Behaviour:
- Reset: all registers 0; o_ribs_rsp = 0; o_ribs_rdata = 0; o_irq = 0; prescaler counters 0; LO/HI shadows 0.
- Address map, channel c at base c*0x20 when addr[10] = 0, c = addr[9:5]:
  - +0x00 CTRL: bit0 EN, bit1 ARL (auto-reload on match), bit2 OS (one-shot), bit3 IE.
  - +0x04 PRESC[PRE_W-1:0].
  - +0x08 CNT_LO; +0x0C CNT_HI.
  - +0x10 CMP_LO; +0x14 CMP_HI.
  - +0x18 STAT: bit0 PEND, write-1-to-clear.
  - 0x400 IRQ_VEC: read-only, {pending & IE}.
- Unmapped offset, or c >= N_CH: read returns 0, write ignored, response still given.
- Bits at or above CNT_W or PRE_W, and all HI registers when CNT_W = 32: read 0, writes ignored.
- Handshake:
  - o_ribs_gnt = i_ribs_req & (~o_ribs_rsp | i_ribs_rdy) (combinational). One outstanding transfer.
  - Accept = req & gnt. o_ribs_rsp rises the cycle after accept, with rdata registered.
  - rsp holds, with rdata stable, until i_ribs_rdy is high. Back-to-back accept in the rdy cycle keeps rsp high with new data.
- Writes commit on the accept edge. Only byte lanes with mask = 1 are written; mask = 0 leaves the register unchanged.
- Prescaler:
  - When EN = 1, pcnt increments each cycle.
  - When pcnt == PRESC: tick pulses, pcnt <= 0. PRESC = 0 ticks every cycle.
  - EN = 0 holds pcnt at 0.
- Counting on tick:
  - If CNT == CMP: set PEND. CNT <= 0 if ARL, else CNT + 1. If OS, clear EN.
  - Otherwise CNT <= CNT + 1.
  - Wrap from 2^CNT_W-1 to 0 without setting PEND unless CMP matches.
- Coherent read:
  - Reading CNT_LO latches CNT[CNT_W-1:32] into a per-channel shadow, same edge.
  - Reading CNT_HI returns the shadow, not the live value.
  - CMP reads are direct.
- Simultaneous events:
  - Bus write to CNT_LO or CNT_HI on a tick cycle: write wins for the written lanes; other counter bits keep their pre-tick value, with no increment that cycle.
  - W1C of PEND in the same cycle as a new match: set wins.
  - Write of EN = 0 on a tick cycle: that tick still counts.
  - Software writing CTRL in the same cycle as the OS clear: the written value wins.
- Reset mid-transfer drops rsp the next cycle; the transfer is lost.

Decomposition:
- Package rib_timer_pkg:
  - register offsets (CTRL, PRESC, CNT_LO, CNT_HI, CMP_LO, CMP_HI, STAT, IRQ_VEC);
  - CTRL bit indices;
  - channel stride 0x20;
  - byte-mask merge function.
- Sub-module rib_timer_chan, instanced N_CH times: prescaler, counter, compare, PEND, shadow, OS/ARL logic; takes decoded write strobes and lanes.
- Top level holds decode, read mux and handshake.

Test Plan:
- Reset, then read CTRL/CNT_LO of ch0 -> 0. Write CTRL = 0x1 with mask 0xF, read CNT_LO ~10 cycles later -> nonzero and incrementing by 1 per cycle.
- ch1: PRESC = 3, CMP = 5, CTRL = 0xB (EN|ARL|IE) -> o_irq[1] rises after 24 enabled cycles; CNT returns to 0. W1C STAT = 1 -> o_irq[1] = 0; it re-fires after 24 more cycles.
- ch2 one-shot: CMP = 2, CTRL = 0x5 -> PEND set once; CTRL reads 0x4; CNT frozen at 3.
- Write CNT_HI = 0, CNT_LO = 0xFFFFFFFE, EN. Read LO then HI across the carry -> HI is the shadow consistent with the LO read (0 if LO read before the wrap).
- i_ribs_rdy held 0 for 3 cycles -> rsp and rdata stable, gnt = 0 for a pending second req. Then rdy = 1 -> gnt = 1 in that cycle.
- Write CTRL with mask 0x0 -> unchanged. Access ch index >= N_CH -> rdata 0, rsp given. Write CNT on a tick cycle -> written value read back with no increment.
